// File: rtl/prio_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : prio_scheduler
// Purpose  : Grants one prepared priority queue per packet. The default build
//            uses strict priority. Defining PRIO_SCHEDULER_WRR_EN adds a
//            weighted-round-robin mode, selected at run time by sp0_wrr1.
// Revision : 1.0 - initial release
// ============================================================================
module prio_scheduler #(
    parameter int num_of_priorities = 8,
    parameter int wrr_weight_width  = 5,
    localparam int ID_W = (num_of_priorities > 1) ? $clog2(num_of_priorities) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sp0_wrr1,
    input  logic [wrr_weight_width-1:0]  wrr_weight,
    input  logic [num_of_priorities-1:0] prepared,
    input  logic                         ready,
    input  logic                         pkt_done,
    output logic [num_of_priorities-1:0] grant,
    output logic [ID_W-1:0]              grant_id,
    output logic                         grant_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [num_of_priorities-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]                grant_id_q, grant_id_d;
    logic                           grant_vld_q, grant_vld_d;
    logic [ID_W-1:0]                sp_idx;
    logic [ID_W-1:0]                sel_idx;

    // Lowest prepared index wins in strict priority.
    always_comb begin
        sp_idx = '0;
        for (int i = num_of_priorities - 1; i >= 0; i--) begin
            if (prepared[i]) sp_idx = ID_W'(i);
        end
    end

`ifdef PRIO_SCHEDULER_WRR_EN
    logic [ID_W-1:0]             ptr_q, ptr_d;
    logic [wrr_weight_width-1:0] crd_q, crd_d;
    logic [ID_W-1:0]             nxt_idx;
    logic [ID_W-1:0]             wrr_idx;
    logic [ID_W-1:0]             wrr_ptr;
    logic [wrr_weight_width-1:0] wrr_crd;
    logic [wrr_weight_width-1:0] crd_load;

    // Scan offsets from far to near so the nearest prepared queue after ptr
    // wins; offset num_of_priorities wraps back to ptr itself.
    always_comb begin
        int j;
        nxt_idx = ptr_q;
        for (int off = num_of_priorities; off >= 1; off--) begin
            j = int'(ptr_q) + off;
            if (j >= num_of_priorities) j = j - num_of_priorities;
            if (prepared[j]) nxt_idx = ID_W'(j);
        end
    end

    // A zero weight behaves as one packet per turn.
    assign crd_load = (wrr_weight == '0) ? '0 : (wrr_weight - wrr_weight_width'(1));

    always_comb begin
        if (prepared[ptr_q] && (crd_q != '0)) begin
            wrr_idx = ptr_q;
            wrr_ptr = ptr_q;
            wrr_crd = crd_q - wrr_weight_width'(1);
        end else begin
            wrr_idx = nxt_idx;
            wrr_ptr = nxt_idx;
            wrr_crd = crd_load;
        end
    end

    assign sel_idx = sp0_wrr1 ? wrr_idx : sp_idx;
`else
    logic unused_cfg;
    assign unused_cfg = ^{sp0_wrr1, wrr_weight};
    assign sel_idx    = sp_idx;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        grant_vld_d = grant_vld_q;
`ifdef PRIO_SCHEDULER_WRR_EN
        ptr_d       = ptr_q;
        crd_d       = crd_q;
`endif
        case (state_q)
            IDLE: begin
                if (ready && (|prepared)) begin
                    state_d          = SERVE;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    grant_id_d       = sel_idx;
                    grant_vld_d      = 1'b1;
`ifdef PRIO_SCHEDULER_WRR_EN
                    if (sp0_wrr1) begin
                        ptr_d = wrr_ptr;
                        crd_d = wrr_crd;
                    end
`endif
                end
            end
            SERVE: begin
                if (pkt_done) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    grant_id_d  = '0;
                    grant_vld_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                grant_id_d  = '0;
                grant_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
`ifdef PRIO_SCHEDULER_WRR_EN
            ptr_q       <= '0;
            crd_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            grant_vld_q <= grant_vld_d;
`ifdef PRIO_SCHEDULER_WRR_EN
            ptr_q       <= ptr_d;
            crd_q       <= crd_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign grant_vld = grant_vld_q;

endmodule
`default_nettype wire
